// File: rtl/test_register_bank_if.sv
// Parser-side write bus and bring-up read port of the register bank.
// The master drives the addresses, data and enable. The bank returns the read data.
interface test_register_bank_if #(
  parameter int WORD_WIDTH = 8,
  parameter int DW         = 32
);
  logic [WORD_WIDTH-1:0] i_w_addr;
  logic [DW-1:0]         i_w_data;
  logic                  i_w_en;
  logic [WORD_WIDTH-1:0] i_r_addr;
  logic [DW-1:0]         o_r_data;

  modport master (
    output i_w_addr, i_w_data, i_w_en, i_r_addr,
    input  o_r_data
  );

  modport slave (
    input  i_w_addr, i_w_data, i_w_en, i_r_addr,
    output o_r_data
  );
endinterface

// File: rtl/test_register_bank.sv
// Register bank fed by the UART command parser. Each write-enable high period produces one write.
// Provides pulse registers, per-register strobes, a registered read port and bring-up counters.
module test_register_bank #(
  parameter int                        WORD_WIDTH  = 8,
  parameter int                        VALUE_WORDS = 4,
  parameter int                        N_REGS      = 16,
  parameter logic [N_REGS-1:0]         PULSE_MASK  = 16'h0001,
  parameter logic [N_REGS*VALUE_WORDS*WORD_WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic                       clk,
  input  logic                       i_reset,
  test_register_bank_if.slave        bus,
  output logic [N_REGS*VALUE_WORDS*WORD_WIDTH-1:0] o_regs,
  output logic [N_REGS-1:0]          o_strobe,
  output logic [15:0]                o_wr_count,
  output logic                       o_err,
  input  logic                       i_err_clr
);
  localparam int DW = VALUE_WORDS * WORD_WIDTH;
  localparam logic [WORD_WIDTH-1:0] N_REGS_W = WORD_WIDTH'(N_REGS);

  logic [DW-1:0]     regs [N_REGS];
  logic              w_en_d;
  logic [N_REGS-1:0] strobe;
  logic [15:0]       wr_count;
  logic              err;
  logic [DW-1:0]     r_data;
  logic [DW-1:0]     r_data_next;

  logic accept;
  logic in_range;

  assign accept   = bus.i_w_en & ~w_en_d;
  assign in_range = bus.i_w_addr < N_REGS_W;

  // Read mux sees pre-edge contents, so a same-cycle write to the same address returns the old value.
  always_comb begin
    // NOTE: default first so no path through this block leaves r_data_next unassigned (no latch).
    r_data_next = '0;
    if (bus.i_r_addr < N_REGS_W) begin
      for (int k = 0; k < N_REGS; k++) begin
        if (bus.i_r_addr == WORD_WIDTH'(k)) r_data_next = regs[k];
      end
    end else if (bus.i_r_addr == N_REGS_W) begin
      r_data_next = DW'(wr_count);
    end
  end

  always_ff @(posedge clk or posedge i_reset) begin
    if (i_reset) begin
      // NOTE: the register array is real flops with per-entry reset values, so it is reset here like any other state.
      for (int k = 0; k < N_REGS; k++) regs[k] <= RESET_VALUE[k*DW +: DW];
      w_en_d   <= 1'b0;
      strobe   <= '0;
      wr_count <= '0;
      err      <= 1'b0;
      r_data   <= '0;
    end else begin
      // NOTE: non-blocking throughout, so every read in this block sees pre-edge state.
      w_en_d <= bus.i_w_en;
      strobe <= '0;
      r_data <= r_data_next;

      // Pulse registers fall back to their reset value unless reloaded below.
      for (int k = 0; k < N_REGS; k++) begin
        if (PULSE_MASK[k]) regs[k] <= RESET_VALUE[k*DW +: DW];
      end

      if (accept && in_range) begin
        for (int k = 0; k < N_REGS; k++) begin
          if (bus.i_w_addr == WORD_WIDTH'(k)) begin
            regs[k]   <= bus.i_w_data;
            strobe[k] <= 1'b1;
          end
        end
        if (wr_count != 16'hFFFF) wr_count <= wr_count + 16'd1;
      end

      // A new out-of-range attempt wins over a simultaneous clear.
      if (accept && !in_range) err <= 1'b1;
      else if (i_err_clr)      err <= 1'b0;
    end
  end

  for (genvar k = 0; k < N_REGS; k++) begin : g_pack
    assign o_regs[k*DW +: DW] = regs[k];
  end

  assign o_strobe     = strobe;
  assign o_wr_count   = wr_count;
  assign o_err        = err;
  assign bus.o_r_data = r_data;
endmodule

// File: tb/tb_test_register_bank.sv
// Directed bench for test_register_bank. A per-cycle vector table is followed by sequences
// covering saturation and asynchronous reset.
module tb_test_register_bank;
  localparam int WW = 8;
  localparam int DW = 32;
  localparam int NR = 16;

  logic          clk = 1'b0;
  logic          i_reset;
  logic          i_err_clr;
  logic [NR*DW-1:0] o_regs;
  logic [NR-1:0] o_strobe;
  logic [15:0]   o_wr_count;
  logic          o_err;

  test_register_bank_if #(.WORD_WIDTH(WW), .DW(DW)) bus ();

  test_register_bank dut (
    .clk        (clk),
    .i_reset    (i_reset),
    .bus        (bus),
    .o_regs     (o_regs),
    .o_strobe   (o_strobe),
    .o_wr_count (o_wr_count),
    .o_err      (o_err),
    .i_err_clr  (i_err_clr)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic          w_en;
    logic [WW-1:0] w_addr;
    logic [DW-1:0] w_data;
    logic [WW-1:0] r_addr;
    logic          err_clr;
    logic [NR-1:0] e_strobe;
    logic [15:0]   e_count;
    logic          e_err;
    logic [DW-1:0] e_rdata;
    int            c_addr;
    logic [DW-1:0] e_reg;
  } vec_t;

  function automatic vec_t mk(logic en, logic [WW-1:0] wa, logic [DW-1:0] wd, logic [WW-1:0] ra,
                              logic ec, logic [NR-1:0] es, logic [15:0] ecnt, logic ee,
                              logic [DW-1:0] erd, int ca, logic [DW-1:0] erg);
    vec_t v;
    v.w_en = en; v.w_addr = wa; v.w_data = wd; v.r_addr = ra; v.err_clr = ec;
    v.e_strobe = es; v.e_count = ecnt; v.e_err = ee; v.e_rdata = erd; v.c_addr = ca; v.e_reg = erg;
    return v;
  endfunction

  task automatic drive(input logic en, input logic [WW-1:0] wa, input logic [DW-1:0] wd,
                       input logic [WW-1:0] ra, input logic ec);
    @(negedge clk);
    bus.i_w_en = en; bus.i_w_addr = wa; bus.i_w_data = wd; bus.i_r_addr = ra; i_err_clr = ec;
    @(posedge clk);
    #1;
  endtask

  vec_t vecs[25];

  initial begin
    // Columns: en, waddr, wdata, raddr, err_clr | strobe, count, err, rdata, reg idx, reg value.
    vecs[0]  = mk(1, 3,  32'hDEADBEEF, 3,   0, 16'h0008, 1, 0, 32'h0,        3,  32'hDEADBEEF);
    vecs[1]  = mk(0, 3,  32'h0,        3,   0, 16'h0000, 1, 0, 32'hDEADBEEF, 3,  32'hDEADBEEF);
    vecs[2]  = mk(1, 2,  32'd1,        16,  0, 16'h0004, 2, 0, 32'd1,        2,  32'd1);
    vecs[3]  = mk(1, 2,  32'd2,        16,  0, 16'h0000, 2, 0, 32'd2,        2,  32'd1);
    vecs[4]  = mk(1, 2,  32'd3,        16,  0, 16'h0000, 2, 0, 32'd2,        2,  32'd1);
    vecs[5]  = mk(1, 2,  32'd4,        16,  0, 16'h0000, 2, 0, 32'd2,        2,  32'd1);
    vecs[6]  = mk(1, 2,  32'd5,        16,  0, 16'h0000, 2, 0, 32'd2,        2,  32'd1);
    vecs[7]  = mk(0, 2,  32'd0,        2,   0, 16'h0000, 2, 0, 32'd1,        2,  32'd1);
    vecs[8]  = mk(1, 0,  32'hA5,       0,   0, 16'h0001, 3, 0, 32'h0,        0,  32'hA5);
    vecs[9]  = mk(0, 0,  32'h0,        0,   0, 16'h0000, 3, 0, 32'hA5,       0,  32'h0);
    vecs[10] = mk(1, 0,  32'h5A,       0,   0, 16'h0001, 4, 0, 32'h0,        0,  32'h5A);
    vecs[11] = mk(0, 0,  32'h0,        0,   0, 16'h0000, 4, 0, 32'h5A,       0,  32'h0);
    vecs[12] = mk(1, 16, 32'hFF,       16,  0, 16'h0000, 4, 1, 32'd4,        3,  32'hDEADBEEF);
    vecs[13] = mk(0, 16, 32'h0,        16,  0, 16'h0000, 4, 1, 32'd4,        0,  32'h0);
    vecs[14] = mk(1, 20, 32'h77,       16,  1, 16'h0000, 4, 1, 32'd4,        2,  32'd1);
    vecs[15] = mk(0, 20, 32'h0,        16,  1, 16'h0000, 4, 0, 32'd4,        2,  32'd1);
    vecs[16] = mk(0, 0,  32'h0,        16,  0, 16'h0000, 4, 0, 32'd4,        0,  32'h0);
    vecs[17] = mk(1, 5,  32'h1111,     5,   0, 16'h0020, 5, 0, 32'h0,        5,  32'h1111);
    vecs[18] = mk(0, 5,  32'h0,        5,   0, 16'h0000, 5, 0, 32'h1111,     5,  32'h1111);
    vecs[19] = mk(1, 5,  32'h1234,     5,   0, 16'h0020, 6, 0, 32'h1111,     5,  32'h1234);
    vecs[20] = mk(0, 5,  32'h0,        5,   0, 16'h0000, 6, 0, 32'h1234,     5,  32'h1234);
    vecs[21] = mk(0, 0,  32'h0,        200, 0, 16'h0000, 6, 0, 32'h0,        5,  32'h1234);
    vecs[22] = mk(0, 0,  32'h0,        16,  0, 16'h0000, 6, 0, 32'd6,        3,  32'hDEADBEEF);
    vecs[23] = mk(1, 15, 32'hCAFEF00D, 16,  0, 16'h8000, 7, 0, 32'd6,        15, 32'hCAFEF00D);
    vecs[24] = mk(0, 15, 32'h0,        15,  0, 16'h0000, 7, 0, 32'hCAFEF00D, 15, 32'hCAFEF00D);

    i_reset = 1'b1; i_err_clr = 1'b0;
    bus.i_w_en = 1'b0; bus.i_w_addr = '0; bus.i_w_data = '0; bus.i_r_addr = '0;
    #1;
    check("rst_regs",   {63'd0, o_regs == '0}, 64'd1);
    check("rst_strobe", 64'(o_strobe), 64'd0);
    check("rst_count",  64'(o_wr_count), 64'd0);
    check("rst_err",    64'(o_err), 64'd0);
    check("rst_rdata",  64'(bus.o_r_data), 64'd0);
    @(negedge clk);
    @(negedge clk);
    i_reset = 1'b0;

    for (int i = 0; i < 25; i++) begin
      drive(vecs[i].w_en, vecs[i].w_addr, vecs[i].w_data, vecs[i].r_addr, vecs[i].err_clr);
      check($sformatf("v%0d_strobe", i), 64'(o_strobe), 64'(vecs[i].e_strobe));
      check($sformatf("v%0d_count", i),  64'(o_wr_count), 64'(vecs[i].e_count));
      check($sformatf("v%0d_err", i),    64'(o_err), 64'(vecs[i].e_err));
      check($sformatf("v%0d_rdata", i),  64'(bus.o_r_data), 64'(vecs[i].e_rdata));
      check($sformatf("v%0d_reg%0d", i, vecs[i].c_addr),
            64'(o_regs[vecs[i].c_addr*DW +: DW]), 64'(vecs[i].e_reg));
    end

    // Saturation: preload the counter just below full scale, then three more valid writes.
    @(negedge clk);
    force dut.wr_count = 16'hFFFE;
    #1 release dut.wr_count;
    check("sat_preload", 64'(o_wr_count), 64'hFFFE);
    for (int n = 0; n < 3; n++) begin
      drive(1, 8, 32'h100 + 32'(n), 16, 0);
      check($sformatf("sat_count%0d", n), 64'(o_wr_count), 64'hFFFF);
      check($sformatf("sat_strobe%0d", n), 64'(o_strobe), 64'h0100);
      drive(0, 8, 32'h0, 16, 0);
    end
    check("sat_rdata", 64'(bus.o_r_data), 64'h0000FFFF);
    check("sat_reg8",  64'(o_regs[8*DW +: DW]), 64'h102);

    // Asynchronous reset while a write is in flight, with the error flag set beforehand.
    drive(1, 16, 32'h0, 3, 0);
    drive(0, 16, 32'h0, 3, 0);
    check("pre_rst_err", 64'(o_err), 64'd1);
    @(negedge clk);
    bus.i_w_en = 1'b1; bus.i_w_addr = 7; bus.i_w_data = 32'h77;
    #2 i_reset = 1'b1;
    #1;
    check("mid_rst_regs",   {63'd0, o_regs == '0}, 64'd1);
    check("mid_rst_count",  64'(o_wr_count), 64'd0);
    check("mid_rst_err",    64'(o_err), 64'd0);
    check("mid_rst_rdata",  64'(bus.o_r_data), 64'd0);
    check("mid_rst_strobe", 64'(o_strobe), 64'd0);
    @(negedge clk);
    i_reset = 1'b0;
    @(posedge clk);
    #1;
    check("post_rst_reg7",   64'(o_regs[7*DW +: DW]), 64'h77);
    check("post_rst_strobe", 64'(o_strobe), 64'h0080);
    check("post_rst_count",  64'(o_wr_count), 64'd1);
    @(posedge clk);
    #1;
    check("post_rst_hold_count",  64'(o_wr_count), 64'd1);
    check("post_rst_hold_strobe", 64'(o_strobe), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
